mcp_useq: RTL



---
 rtl/mcp_useq_pkg.sv | 24 ++
 rtl/mcp_useq_if.sv | 27 ++
 rtl/mcp_useq_retstk.sv | 58 +++++
 rtl/mcp_useq.sv | 118 +++++++++++
 4 files changed

// File: rtl/mcp_useq_pkg.sv
// Shared types for the MCP-1631 microprogram sequencer: sequencing ops,
// sequencer states and the location-counter width.
package lsi_useq_pkg;

   localparam int unsigned LC_W = 11;

   typedef logic [LC_W-1:0] lc_t;

   typedef enum logic [2:0] {
      USQ_INC  = 3'd0,
      USQ_JMP  = 3'd1,
      USQ_CALL = 3'd2,
      USQ_RET  = 3'd3,
      USQ_CJMP = 3'd4,
      USQ_HALT = 3'd5
   } usq_op_e;

   typedef enum logic [1:0] {
      S_RST  = 2'd0,
      S_RUN  = 2'd1,
      S_HALT = 2'd2
   } useq_state_e;

endpackage

// File: rtl/mcp_useq_if.sv
// Control-decode <-> sequencer bus: the current microword's sequencing
// fields in, the MicROM address and sequencer status out.
interface mcp_useq_if;
   import lsi_useq_pkg::*;

   logic       pin_stall;
   logic [2:0] pin_op;
   lc_t        pin_na;
   logic       pin_cond;
   logic       pin_trap;
   lc_t        pin_tvec;
   lc_t        pin_lc;
   logic       pin_mv;
   logic [3:0] pin_sp;
   logic       pin_err;

   modport master (
      output pin_stall, pin_op, pin_na, pin_cond, pin_trap, pin_tvec,
      input  pin_lc, pin_mv, pin_sp, pin_err
   );

   modport slave (
      input  pin_stall, pin_op, pin_na, pin_cond, pin_trap, pin_tvec,
      output pin_lc, pin_mv, pin_sp, pin_err
   );

endinterface

// File: rtl/mcp_useq_retstk.sv
// Return-address LIFO for the sequencer. Push on a full stack and pop on an
// empty stack are ignored here; the caller owns the error policy.
module mcp_retstk
   import lsi_useq_pkg::*;
#(
   parameter int unsigned STK_DEPTH = 4
) (
   input  logic       pin_clk,
   input  logic       pin_nrst,
   input  logic       push,
   input  logic       pop,
   input  lc_t        din,
   output lc_t        top,
   output logic [3:0] depth,
   output logic       full,
   output logic       empty
);

   lc_t        mem_q [STK_DEPTH];
   lc_t        mem_d [STK_DEPTH];
   logic [3:0] depth_q;
   logic [3:0] depth_d;

   assign full  = (depth_q == 4'(STK_DEPTH));
   assign empty = (depth_q == '0);
   assign depth = depth_q;

   always_comb begin
      mem_d   = mem_q;
      depth_d = depth_q;
      if (push && !full) begin
         for (int unsigned i = 0; i < STK_DEPTH; i++) begin
            if (4'(i) == depth_q) mem_d[i] = din;
         end
         depth_d = depth_q + 4'd1;
      end else if (pop && !empty) begin
         depth_d = depth_q - 4'd1;
      end
   end

   always_comb begin
      top = '0;
      for (int unsigned i = 0; i < STK_DEPTH; i++) begin
         if (4'(i) + 4'd1 == depth_q) top = mem_q[i];
      end
   end

   always_ff @(posedge pin_clk or negedge pin_nrst) begin
      if (!pin_nrst) begin
         depth_q <= '0;
         mem_q   <= '{default: '0};
      end else begin
         depth_q <= depth_d;
         mem_q   <= mem_d;
      end
   end

endmodule

// File: rtl/mcp_useq.sv
// MicROM location-counter sequencer: pc tracks the word on the ROM output,
// and the next address is decoded combinationally from that word's op.
module mcp_useq
   import lsi_useq_pkg::*;
#(
   parameter lc_t         RESET_VEC = 11'h000,
   parameter int unsigned STK_DEPTH = 4
) (
   input  logic         pin_clk,
   input  logic         pin_nrst,
   mcp_useq_if.slave    bus
);

   useq_state_e state_q, state_d;
   lc_t         pc_q, pc_d;
   logic        err_q, err_d;
   lc_t         lc;
   lc_t         pc_inc;
   logic        mv;
   logic        push, pop;
   lc_t         stk_top;
   logic [3:0]  stk_depth;
   logic        stk_full, stk_empty;

   assign pc_inc = pc_q + LC_W'(1);

   mcp_retstk #(.STK_DEPTH(STK_DEPTH)) u_retstk (
      .pin_clk  (pin_clk),
      .pin_nrst (pin_nrst),
      .push     (push),
      .pop      (pop),
      .din      (pc_inc),
      .top      (stk_top),
      .depth    (stk_depth),
      .full     (stk_full),
      .empty    (stk_empty)
   );

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      err_d   = err_q;
      lc      = pc_q;
      mv      = 1'b0;
      push    = 1'b0;
      pop     = 1'b0;
      case (state_q)
         S_RST: begin
            lc      = RESET_VEC;
            pc_d    = RESET_VEC;
            state_d = S_RUN;
         end
         S_RUN: begin
            mv = 1'b1;
            if (!bus.pin_stall) begin
               if (bus.pin_trap) begin
                  lc = bus.pin_tvec;
               end else begin
                  case (bus.pin_op)
                     USQ_JMP: lc = bus.pin_na;
                     USQ_CALL: begin
                        // jump is taken even when the return push is dropped
                        lc = bus.pin_na;
                        if (stk_full) err_d = 1'b1;
                        else          push  = 1'b1;
                     end
                     USQ_RET: begin
                        if (stk_empty) begin
                           lc    = RESET_VEC;
                           err_d = 1'b1;
                        end else begin
                           lc  = stk_top;
                           pop = 1'b1;
                        end
                     end
                     USQ_CJMP: lc = bus.pin_cond ? bus.pin_na : pc_inc;
                     USQ_HALT: begin
                        lc      = pc_q;
                        state_d = S_HALT;
                     end
                     default: lc = pc_inc;
                  endcase
               end
               pc_d = lc;
            end
         end
         S_HALT: begin
            if (bus.pin_trap && !bus.pin_stall) begin
               lc      = bus.pin_tvec;
               pc_d    = bus.pin_tvec;
               state_d = S_RUN;
            end
         end
         default: begin
            lc      = RESET_VEC;
            state_d = S_RST;
         end
      endcase
   end

   always_ff @(posedge pin_clk or negedge pin_nrst) begin
      if (!pin_nrst) begin
         state_q <= S_RST;
         pc_q    <= RESET_VEC;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         err_q   <= err_d;
      end
   end

   assign bus.pin_lc  = lc;
   assign bus.pin_mv  = mv;
   assign bus.pin_sp  = stk_depth;
   assign bus.pin_err = err_q;

endmodule
